// File: rtl/gcl_pkg.sv
// Shared types and constants for the dual-bank gate-control-list engine.
package gcl_pkg;

    // Engine sequencing: idle, RAM address phase, gate load phase.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LOAD = 2'd2
    } gcl_state_e;

    localparam logic MODE_QBV = 1'b0;
    localparam logic MODE_QCH = 1'b1;

    // Gate vectors come out of reset fully open; sliced to the width in use.
    localparam int unsigned GATE_MAX_W = 64;
    localparam logic [GATE_MAX_W-1:0] GATE_OPEN = '1;

endpackage

// File: rtl/gcl_dual_bank_gate_ctrl_if.sv
// Host configuration, time-slot and gate-vector signals of the GCL engine.
interface gcl_dual_bank_gate_ctrl_if #(
    parameter int unsigned QUEUE_NUM = 8,
    parameter int unsigned IN_GATE_W = 2,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned SLOT_W    = 10
);
    localparam int unsigned ENTRY_W = IN_GATE_W + QUEUE_NUM;

    logic [ADDR_W-1:0]    iv_cfg_addr;
    logic [ENTRY_W-1:0]   iv_cfg_wdata;
    logic                 i_cfg_wr;
    logic                 i_cfg_rd;
    logic [ENTRY_W-1:0]   ov_cfg_rdata;
    logic                 o_cfg_rdata_valid;
    logic [ADDR_W-1:0]    iv_cfg_list_len;
    logic                 i_cfg_commit;
    logic                 o_commit_pending;
    logic                 o_cfg_wr_drop;
    logic                 i_qbv_or_qch;
    logic [SLOT_W-1:0]    iv_time_slot;
    logic                 i_time_slot_switch;
    logic [IN_GATE_W-1:0] ov_in_gate_ctrl_vector;
    logic [QUEUE_NUM-1:0] ov_out_gate_ctrl_vector;
    logic                 o_oper_bank;
    logic                 o_slot_overrun;

    modport master (
        output iv_cfg_addr, iv_cfg_wdata, i_cfg_wr, i_cfg_rd, iv_cfg_list_len, i_cfg_commit,
               i_qbv_or_qch, iv_time_slot, i_time_slot_switch,
        input  ov_cfg_rdata, o_cfg_rdata_valid, o_commit_pending, o_cfg_wr_drop,
               ov_in_gate_ctrl_vector, ov_out_gate_ctrl_vector, o_oper_bank, o_slot_overrun
    );

    modport slave (
        input  iv_cfg_addr, iv_cfg_wdata, i_cfg_wr, i_cfg_rd, iv_cfg_list_len, i_cfg_commit,
               i_qbv_or_qch, iv_time_slot, i_time_slot_switch,
        output ov_cfg_rdata, o_cfg_rdata_valid, o_commit_pending, o_cfg_wr_drop,
               ov_in_gate_ctrl_vector, ov_out_gate_ctrl_vector, o_oper_bank, o_slot_overrun
    );

endinterface

// File: rtl/gcl_dpram.sv
// True dual-port RAM holding both GCL banks; address MSB selects the bank.
// Both ports read with one clock of latency and return pre-write data on collision.
module gcl_dpram #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 10
) (
    input  logic          clk_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic          a_we_i,
    input  logic [DW-1:0] a_wdata_i,
    input  logic          a_rd_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    input  logic          b_we_i,
    input  logic [DW-1:0] b_wdata_i,
    input  logic          b_rd_i,
    output logic [DW-1:0] b_rdata_o
);
    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] mem [Depth];
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    // Writes and registered reads on both ports; no reset on storage.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem[a_addr_i] <= a_wdata_i;
        end
        if (b_we_i) begin
            mem[b_addr_i] <= b_wdata_i;
        end
        if (a_rd_i) begin
            a_rdata_q <= mem[a_addr_i];
        end
        if (b_rd_i) begin
            b_rdata_q <= mem[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/gcl_dual_bank_gate_ctrl.sv
// Gate-control-list engine: walks the oper bank on each time-slot switch (Qbv)
// or derives CQF ping-pong gates from the slot parity (Qch). The host edits the
// admin bank; a commit swaps banks at the next slot-0 switch.
module gcl_dual_bank_gate_ctrl
    import gcl_pkg::*;
#(
    parameter int unsigned QUEUE_NUM = 8,
    parameter int unsigned IN_GATE_W = 2,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned SLOT_W    = 10
) (
    input logic i_clk,
    input logic i_rst,
    gcl_dual_bank_gate_ctrl_if.slave bus
);
    localparam int unsigned ENTRY_W = IN_GATE_W + QUEUE_NUM;

    gcl_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    gcl_index_q, gcl_index_d;
    logic [ADDR_W-1:0]    oper_len_q, oper_len_d;
    logic                 oper_bank_q, oper_bank_d;
    logic                 commit_pending_q, commit_pending_d;
    logic                 pend_sw_q, pend_sw_d;
    logic [SLOT_W-1:0]    pend_slot_q, pend_slot_d;
    logic                 slot_overrun_q, slot_overrun_d;
    logic [IN_GATE_W-1:0] in_gate_q, in_gate_d;
    logic [QUEUE_NUM-1:0] out_gate_q, out_gate_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic                 wr_drop_q, wr_drop_d;

    logic                 go;
    logic [SLOT_W-1:0]    slot_eff;
    logic [ENTRY_W-1:0]   eng_rdata;
    logic [ENTRY_W-1:0]   host_rdata;

    gcl_dpram #(
        .AW (ADDR_W + 1),
        .DW (ENTRY_W)
    ) u_dpram (
        .clk_i     (i_clk),
        .a_addr_i  ({~oper_bank_q, bus.iv_cfg_addr}),
        .a_we_i    (bus.i_cfg_wr & ~commit_pending_q),
        .a_wdata_i (bus.iv_cfg_wdata),
        .a_rd_i    (bus.i_cfg_rd),
        .a_rdata_o (host_rdata),
        .b_addr_i  ({oper_bank_q, gcl_index_q}),
        .b_we_i    (1'b0),
        .b_wdata_i ('0),
        .b_rd_i    (state_q == S_READ),
        .b_rdata_o (eng_rdata)
    );

    // Next-state: host strobes, commit/swap, switch processing and engine sequencing.
    always_comb begin
        state_d          = state_q;
        gcl_index_d      = gcl_index_q;
        oper_len_d       = oper_len_q;
        oper_bank_d      = oper_bank_q;
        commit_pending_d = commit_pending_q;
        pend_sw_d        = pend_sw_q;
        pend_slot_d      = pend_slot_q;
        slot_overrun_d   = slot_overrun_q;
        in_gate_d        = in_gate_q;
        out_gate_d       = out_gate_q;
        rdata_valid_d    = bus.i_cfg_rd;
        wr_drop_d        = bus.i_cfg_wr & commit_pending_q;
        go               = 1'b0;
        slot_eff         = bus.iv_time_slot;

        if (bus.i_cfg_commit) begin
            commit_pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // A latched switch is older, so it is served first; a new one queues behind it.
                if (pend_sw_q) begin
                    go          = 1'b1;
                    slot_eff    = pend_slot_q;
                    pend_sw_d   = bus.i_time_slot_switch;
                    pend_slot_d = bus.iv_time_slot;
                end else if (bus.i_time_slot_switch) begin
                    go = 1'b1;
                end

                if (go) begin
                    if (commit_pending_q && (slot_eff == '0)) begin
                        oper_bank_d      = ~oper_bank_q;
                        oper_len_d       = bus.iv_cfg_list_len;
                        commit_pending_d = 1'b0;
                    end
                    if (bus.i_qbv_or_qch == MODE_QCH) begin
                        in_gate_d  = IN_GATE_W'({slot_eff[0], ~slot_eff[0]});
                        out_gate_d = {{(QUEUE_NUM - 2){1'b1}}, ~slot_eff[0], slot_eff[0]};
                    end else begin
                        if (slot_eff == '0) begin
                            gcl_index_d = '0;
                        end else if (gcl_index_q == oper_len_q) begin
                            gcl_index_d = '0;
                        end else begin
                            gcl_index_d = gcl_index_q + 1'b1;
                        end
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                in_gate_d  = eng_rdata[ENTRY_W-1:QUEUE_NUM];
                out_gate_d = eng_rdata[QUEUE_NUM-1:0];
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While busy, only one switch can wait; anything beyond that is lost.
        if ((state_q != S_IDLE) && bus.i_time_slot_switch) begin
            if (pend_sw_q) begin
                slot_overrun_d = 1'b1;
            end else begin
                pend_sw_d   = 1'b1;
                pend_slot_d = bus.iv_time_slot;
            end
        end
    end

    // State registers with asynchronous reset; an in-flight read is dropped by returning to idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q          <= S_IDLE;
            gcl_index_q      <= '0;
            oper_len_q       <= '0;
            oper_bank_q      <= 1'b0;
            commit_pending_q <= 1'b0;
            pend_sw_q        <= 1'b0;
            pend_slot_q      <= '0;
            slot_overrun_q   <= 1'b0;
            in_gate_q        <= GATE_OPEN[IN_GATE_W-1:0];
            out_gate_q       <= GATE_OPEN[QUEUE_NUM-1:0];
            rdata_valid_q    <= 1'b0;
            wr_drop_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            gcl_index_q      <= gcl_index_d;
            oper_len_q       <= oper_len_d;
            oper_bank_q      <= oper_bank_d;
            commit_pending_q <= commit_pending_d;
            pend_sw_q        <= pend_sw_d;
            pend_slot_q      <= pend_slot_d;
            slot_overrun_q   <= slot_overrun_d;
            in_gate_q        <= in_gate_d;
            out_gate_q       <= out_gate_d;
            rdata_valid_q    <= rdata_valid_d;
            wr_drop_q        <= wr_drop_d;
        end
    end

    assign bus.ov_cfg_rdata            = host_rdata;
    assign bus.o_cfg_rdata_valid       = rdata_valid_q;
    assign bus.o_commit_pending        = commit_pending_q;
    assign bus.o_cfg_wr_drop           = wr_drop_q;
    assign bus.ov_in_gate_ctrl_vector  = in_gate_q;
    assign bus.ov_out_gate_ctrl_vector = out_gate_q;
    assign bus.o_oper_bank             = oper_bank_q;
    assign bus.o_slot_overrun          = slot_overrun_q;

endmodule

// File: tb/tb_gcl_dual_bank_gate_ctrl.sv
// Scoreboard bench for gcl_dual_bank_gate_ctrl: a reference model of both banks and
// the list walker pushes expected gate vectors / host read data with their due cycle.
module tb_gcl_dual_bank_gate_ctrl;

    localparam int unsigned QUEUE_NUM = 8;
    localparam int unsigned IN_GATE_W = 2;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned SLOT_W    = 10;

    typedef struct {
        int         due;
        logic [1:0] in_g;
        logic [7:0] out_g;
        logic       bank;
    } gexp_t;

    typedef struct {
        int         due;
        logic [9:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t gpop;
    rexp_t rpop;

    // Reference model state.
    logic [9:0] mram [0:2047];
    logic       m_bank = 1'b0;
    logic       m_pend = 1'b0;
    logic [9:0] m_len  = '0;
    logic [9:0] m_idx  = '0;

    gcl_dual_bank_gate_ctrl_if #(
        .QUEUE_NUM (QUEUE_NUM),
        .IN_GATE_W (IN_GATE_W),
        .ADDR_W    (ADDR_W),
        .SLOT_W    (SLOT_W)
    ) bus ();

    gcl_dual_bank_gate_ctrl #(
        .QUEUE_NUM (QUEUE_NUM),
        .IN_GATE_W (IN_GATE_W),
        .ADDR_W    (ADDR_W),
        .SLOT_W    (SLOT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [9:0] addr, input logic [9:0] data);
        logic exp_drop;
        exp_drop          = m_pend;
        bus.iv_cfg_addr   = addr;
        bus.iv_cfg_wdata  = data;
        bus.i_cfg_wr      = 1'b1;
        if (!m_pend) mram[{~m_bank, addr}] = data;
        step();
        bus.i_cfg_wr = 1'b0;
        check_eq("wr_drop", {31'd0, bus.o_cfg_wr_drop}, {31'd0, exp_drop});
    endtask

    task automatic host_read(input logic [9:0] addr);
        rexp_t r;
        bus.iv_cfg_addr = addr;
        bus.i_cfg_rd    = 1'b1;
        r.due  = cyc + 1;
        r.data = mram[{~m_bank, addr}];
        rq.push_back(r);
        step();
        bus.i_cfg_rd = 1'b0;
    endtask

    task automatic commit();
        bus.i_cfg_commit = 1'b1;
        m_pend = 1'b1;
        step();
        bus.i_cfg_commit = 1'b0;
        check_eq("commit_pending", {31'd0, bus.o_commit_pending}, 32'd1);
    endtask

    // Drive one switch and push the model's expected vectors lat cycles after the drive.
    task automatic switch_slot(input logic [9:0] slot, input logic mode, input int lat);
        gexp_t      g;
        logic [9:0] e;
        bus.iv_time_slot       = slot;
        bus.i_qbv_or_qch       = mode;
        bus.i_time_slot_switch = 1'b1;
        if (m_pend && slot == 10'd0) begin
            m_bank = ~m_bank;
            m_len  = bus.iv_cfg_list_len;
            m_pend = 1'b0;
        end
        g.due  = cyc + lat;
        g.bank = m_bank;
        if (mode) begin
            g.in_g  = {slot[0], ~slot[0]};
            g.out_g = {6'h3F, ~slot[0], slot[0]};
        end else begin
            if (slot == 10'd0)       m_idx = '0;
            else if (m_idx == m_len) m_idx = '0;
            else                     m_idx = m_idx + 10'd1;
            e       = mram[{m_bank, m_idx}];
            g.in_g  = e[9:8];
            g.out_g = e[7:0];
        end
        gq.push_back(g);
        step();
        bus.i_time_slot_switch = 1'b0;
    endtask

    // Output side of the scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (gq.size() > 0 && gq[0].due <= cyc) begin
            gpop = gq.pop_front();
            check_eq("gate_due", cyc, gpop.due);
            check_eq("in_gate", {30'd0, bus.ov_in_gate_ctrl_vector}, {30'd0, gpop.in_g});
            check_eq("out_gate", {24'd0, bus.ov_out_gate_ctrl_vector}, {24'd0, gpop.out_g});
            check_eq("oper_bank", {31'd0, bus.o_oper_bank}, {31'd0, gpop.bank});
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            rpop = rq.pop_front();
            check_eq("rd_valid", {31'd0, bus.o_cfg_rdata_valid}, 32'd1);
            check_eq("rd_data", {22'd0, bus.ov_cfg_rdata}, {22'd0, rpop.data});
        end else begin
            check_eq("rd_spurious", {31'd0, bus.o_cfg_rdata_valid}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iv_cfg_addr        = '0;
        bus.iv_cfg_wdata       = '0;
        bus.i_cfg_wr           = 1'b0;
        bus.i_cfg_rd           = 1'b0;
        bus.iv_cfg_list_len    = '0;
        bus.i_cfg_commit       = 1'b0;
        bus.i_qbv_or_qch       = 1'b0;
        bus.iv_time_slot       = '0;
        bus.i_time_slot_switch = 1'b0;
        repeat (3) step();
        check_eq("rst_in_gate", {30'd0, bus.ov_in_gate_ctrl_vector}, 32'h3);
        check_eq("rst_out_gate", {24'd0, bus.ov_out_gate_ctrl_vector}, 32'hFF);
        check_eq("rst_bank", {31'd0, bus.o_oper_bank}, 32'd0);
        check_eq("rst_pending", {31'd0, bus.o_commit_pending}, 32'd0);
        rst = 1'b0;
        step();

        // First list into admin bank 1, committed and walked with wrap.
        host_write(10'd0, 10'h101);
        host_write(10'd1, 10'h202);
        host_write(10'd2, 10'h304);
        host_write(10'd3, 10'h108);
        host_read(10'd3);
        bus.iv_cfg_list_len = 10'd3;
        commit();
        for (int s = 0; s < 6; s++) begin
            switch_slot(10'(s), 1'b0, 3);
            repeat (4) step();
        end
        check_eq("pending_cleared", {31'd0, bus.o_commit_pending}, 32'd0);

        // Second, shorter list into bank 0; commit mid-cycle waits for slot 0.
        host_write(10'd0, 10'h210);
        host_write(10'd1, 10'h120);
        host_write(10'd2, 10'h340);
        host_write(10'd3, 10'h080);
        bus.iv_cfg_list_len = 10'd1;
        switch_slot(10'd2, 1'b0, 3);
        repeat (4) step();
        commit();
        switch_slot(10'd3, 1'b0, 3);
        repeat (4) step();
        check_eq("no_early_swap", {31'd0, bus.o_oper_bank}, 32'd1);
        host_write(10'd0, 10'h3FF);
        host_read(10'd0);
        step();
        switch_slot(10'd0, 1'b0, 3);
        repeat (4) step();
        // Host read of admin addr 3 while the engine is reading the oper bank.
        switch_slot(10'd1, 1'b0, 3);
        host_read(10'd3);
        repeat (4) step();
        switch_slot(10'd2, 1'b0, 3);
        repeat (4) step();

        // Qch ping-pong gates.
        switch_slot(10'd5, 1'b1, 1);
        repeat (3) step();
        switch_slot(10'd6, 1'b1, 1);
        repeat (3) step();

        // Back-to-back switches: third is lost.
        check_eq("overrun_clear", {31'd0, bus.o_slot_overrun}, 32'd0);
        switch_slot(10'd1, 1'b0, 3);
        switch_slot(10'd2, 1'b0, 5);
        bus.iv_time_slot       = 10'd3;
        bus.i_time_slot_switch = 1'b1;
        step();
        bus.i_time_slot_switch = 1'b0;
        repeat (6) step();
        check_eq("overrun_set", {31'd0, bus.o_slot_overrun}, 32'd1);
        switch_slot(10'd4, 1'b0, 3);
        repeat (4) step();
        check_eq("overrun_sticky", {31'd0, bus.o_slot_overrun}, 32'd1);

        // Reset mid-read with a commit pending.
        commit();
        bus.iv_time_slot       = 10'd0;
        bus.i_time_slot_switch = 1'b1;
        step();
        bus.i_time_slot_switch = 1'b0;
        rst = 1'b1;
        #2;
        check_eq("mrst_in_gate", {30'd0, bus.ov_in_gate_ctrl_vector}, 32'h3);
        check_eq("mrst_out_gate", {24'd0, bus.ov_out_gate_ctrl_vector}, 32'hFF);
        check_eq("mrst_bank", {31'd0, bus.o_oper_bank}, 32'd0);
        check_eq("mrst_pending", {31'd0, bus.o_commit_pending}, 32'd0);
        check_eq("mrst_overrun", {31'd0, bus.o_slot_overrun}, 32'd0);
        m_bank = 1'b0;
        m_pend = 1'b0;
        m_len  = '0;
        m_idx  = '0;
        step();
        rst = 1'b0;
        repeat (4) step();
        check_eq("discard_read", {24'd0, bus.ov_out_gate_ctrl_vector}, 32'hFF);

        // RAM contents survive reset: bank 0 entry 0 is still the second list.
        switch_slot(10'd0, 1'b0, 3);
        repeat (6) step();

        check_eq("sb_gate_drain", gq.size(), 32'd0);
        check_eq("sb_rd_drain", rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
